fib_job_sequencer: RTL and testbench
====================================

Name: fib_job_sequencer

Overview:
Sits directly upstream of the synthesized `main` fib core and feeds it jobs. It also collects what the core produces.
- Accepts (n, a, b) jobs on a valid/ready input and buffers them in a small FIFO.
- Launches each job with a single-cycle core_r_enable pulse and holds the init operands stable while the core runs.
- Captures core_result on the rising edge of core_w_enable and returns it, tagged with n, on a valid/ready output.
- A watchdog converts a hung core into a timeout response.

Parameters:
DEPTH, 4, job FIFO entries (power of two, >=2)
TIMEOUT, 1023, max cycles spent in WAIT before a timeout is declared
N_W, 6, width of n
D_W, 32, width of a, b, result

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  job offered
in_ready  out  1  FIFO not full
in_n  in  N_W  job n
in_a  in  D_W  job init_a
in_b  in  D_W  job init_b
out_valid  out  1  response available
out_ready  in  1  consumer accepts response
out_n  out  N_W  n of the completed job
out_result  out  D_W  core result (0 on timeout)
out_timeout  out  1  response produced by watchdog
core_r_enable  out  1  start pulse to core
core_controlArr  out  1  tied 0
core_init_n  out  N_W  to core init_n
core_init_a  out  D_W  to core init_a
core_init_b  out  D_W  to core init_b
core_w_enable  in  1  core done (pulse or level)
core_result  in  D_W  core result
busy  out  1  state!=IDLE or FIFO non-empty

Behaviour:
Reset (async, rst_n=0):
- State IDLE, FIFO empty, watchdog counter 0, w_prev 0.
- All outputs 0, except in_ready, which is 1 once rst_n deasserts.
- Reset mid-job abandons the job; core_r_enable stays 0.

FIFO:
- Push on in_valid&&in_ready.
- in_ready = !full; no pass-through when full.
- Pop occurs only on the IDLE->LAUNCH transition.
- A push into an empty FIFO becomes visible the next cycle.
- When not full, push and pop in the same cycle are both honoured and count is unchanged.
- Pointers wrap modulo DEPTH.

Edge detect:
- w_prev registers core_w_enable every cycle.
- rise = core_w_enable && !w_prev.

FSM:
- IDLE: if FIFO non-empty, go to LAUNCH at the next edge, load the head into the job registers and pop it.
- LAUNCH: lasts exactly 1 cycle.
  - core_r_enable=1 (registered) only in this state.
  - core_init_* = job registers.
  - Goes to WAIT and clears the counter.
- WAIT:
  - core_init_* held stable; counter increments each cycle.
  - On rise: capture core_result into out_result, set out_n=job n, out_timeout=0, go to HOLD.
  - Else if counter==TIMEOUT-1: out_result=0, out_timeout=1, go to HOLD.
  - If rise and timeout occur in the same cycle, rise wins.
- HOLD:
  - out_valid=1; out_* stable until out_valid&&out_ready, then go to IDLE.
  - No new launch while in HOLD; out_valid drops the cycle after the handshake.

Timing and edge-detect rules:
- Minimum latency: push at edge E0; IDLE sees a non-empty FIFO during E0..E1; LAUNCH (core_r_enable high) between E1 and E2.
- A rise seen outside WAIT is ignored.
- A core that holds w_enable high from the previous job must drop it and re-raise it to be detected; otherwise the job times out.
- core_controlArr is constantly 0.

Test Plan:
1. Single job n=40, a=1, b=0 into a model core returning 102334155 after 50 cycles.
   -> core_r_enable high exactly 1 cycle, 2 edges after the push.
   -> init_* stable throughout.
   -> out_valid with out_n=40, out_result=102334155, out_timeout=0.
2. Push n=10,11,12,13 back-to-back while the core is busy, then offer n=14.
   -> in_ready=0 while 4 jobs are queued; n=14 accepted after the first pop.
   -> responses in order: 55, 89, 144, 233, 377.
3. Hold out_ready=0 for 20 cycles after out_valid.
   -> out_* constant, no core_r_enable during the stall.
   -> next launch only after the handshake plus the IDLE cycle.
4. TIMEOUT=16, core never asserts w_enable.
   -> out_valid after 16 WAIT cycles, out_timeout=1, out_result=0, out_n=job n.
   -> following queued job then launches normally.
5. Assert rst_n=0 mid-WAIT with 2 jobs queued.
   -> outputs 0 immediately (async), FIFO empty, busy=0.
   -> after release, a new job runs normally.
6. Level-style core: w_enable stays high until the next r_enable, falls, rises 30 cycles later.
   -> the stale high is ignored; the result is captured on the re-rise.

Source files
------------

// File: rtl/fib_job_sequencer_if.sv
// Job, response and core-side signal bundle for fib_job_sequencer.
// The slave side is the sequencer; the master side is the job source and the fib core.
interface fib_job_sequencer_if #(
   parameter int N_W = 6,
   parameter int D_W = 32
);
   logic           in_valid;
   logic           in_ready;
   logic [N_W-1:0] in_n;
   logic [D_W-1:0] in_a;
   logic [D_W-1:0] in_b;

   logic           out_valid;
   logic           out_ready;
   logic [N_W-1:0] out_n;
   logic [D_W-1:0] out_result;
   logic           out_timeout;

   logic           core_r_enable;
   logic           core_controlArr;
   logic [N_W-1:0] core_init_n;
   logic [D_W-1:0] core_init_a;
   logic [D_W-1:0] core_init_b;
   logic           core_w_enable;
   logic [D_W-1:0] core_result;

   modport master (
      output in_valid, in_n, in_a, in_b, out_ready, core_w_enable, core_result,
      input  in_ready, out_valid, out_n, out_result, out_timeout,
             core_r_enable, core_controlArr, core_init_n, core_init_a, core_init_b
   );

   modport slave (
      input  in_valid, in_n, in_a, in_b, out_ready, core_w_enable, core_result,
      output in_ready, out_valid, out_n, out_result, out_timeout,
             core_r_enable, core_controlArr, core_init_n, core_init_a, core_init_b
   );
endinterface

// File: rtl/fib_job_sequencer.sv
// Queues (n,a,b) jobs, launches them one at a time on the fib core and returns n-tagged results.
// Launch pulse two edges after a push into an idle unit; in_ready drops when the FIFO is full, responses hold until out_ready.
module fib_job_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023,
   parameter int N_W     = 6,
   parameter int D_W     = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   fib_job_sequencer_if.slave bus,
   output logic               busy
);

   typedef struct packed {
      logic [N_W-1:0] n;
      logic [D_W-1:0] a;
      logic [D_W-1:0] b;
   } job_t;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t         state, state_nx;
   job_t           mem [DEPTH];
   job_t           in_job;
   job_t           job;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic [TW-1:0]  wd_cnt;
   logic           w_prev;
   logic           rise;
   logic           wd_expired;
   logic           full, empty;
   logic           push, pop;
   logic           r_en_q;
   logic [N_W-1:0] out_n_q;
   logic [D_W-1:0] out_result_q;
   logic           out_timeout_q;

   assign in_job     = '{n: bus.in_n, a: bus.in_a, b: bus.in_b};
   assign full       = (count == CW'(DEPTH));
   assign empty      = (count == '0);
   assign push       = bus.in_valid && bus.in_ready;
   assign pop        = (state == S_IDLE) && !empty;
   assign rise       = bus.core_w_enable && !w_prev;
   assign wd_expired = (wd_cnt == TW'(TIMEOUT - 1));

   // in_ready is held low while reset is applied, so nothing is accepted then.
   assign bus.in_ready        = rst_n && !full;
   assign bus.out_valid       = (state == S_HOLD);
   assign bus.out_n           = out_n_q;
   assign bus.out_result      = out_result_q;
   assign bus.out_timeout     = out_timeout_q;
   assign bus.core_r_enable   = r_en_q;
   assign bus.core_controlArr = 1'b0;
   assign bus.core_init_n     = job.n;
   assign bus.core_init_a     = job.a;
   assign bus.core_init_b     = job.b;
   assign busy                = (state != S_IDLE) || !empty;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (!empty) state_nx = S_LAUNCH;
         S_LAUNCH: state_nx = S_WAIT;
         S_WAIT:   if (rise || wd_expired) state_nx = S_HOLD;
         S_HOLD:   if (bus.out_ready) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_job;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         job           <= '0;
         wd_cnt        <= '0;
         w_prev        <= 1'b0;
         r_en_q        <= 1'b0;
         out_n_q       <= '0;
         out_result_q  <= '0;
         out_timeout_q <= 1'b0;
      end else begin
         state  <= state_nx;
         w_prev <= bus.core_w_enable;
         r_en_q <= (state_nx == S_LAUNCH);
         count  <= count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            job    <= mem[rd_ptr];
         end
         if (state == S_LAUNCH)    wd_cnt <= '0;
         else if (state == S_WAIT) wd_cnt <= wd_cnt + TW'(1);
         // A genuine completion edge beats a watchdog expiry landing in the same cycle.
         if (state == S_WAIT) begin
            if (rise) begin
               out_n_q       <= job.n;
               out_result_q  <= bus.core_result;
               out_timeout_q <= 1'b0;
            end else if (wd_expired) begin
               out_n_q       <= job.n;
               out_result_q  <= '0;
               out_timeout_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fib_job_sequencer.sv
// Bench for fib_job_sequencer: behavioural fib core, job scoreboard, vector table and corner sequences.
`timescale 1ns/1ps
module tb_fib_job_sequencer;
   localparam int N_W = 6;
   localparam int D_W = 32;
   localparam int NRAND = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic busy, busy2;
   always #5 clk = ~clk;

   fib_job_sequencer_if #(.N_W(N_W), .D_W(D_W)) bus ();
   fib_job_sequencer_if #(.N_W(N_W), .D_W(D_W)) bus2 ();

   fib_job_sequencer #(.DEPTH(4), .TIMEOUT(64), .N_W(N_W), .D_W(D_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
   fib_job_sequencer #(.DEPTH(4), .TIMEOUT(16), .N_W(N_W), .D_W(D_W)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2));

   typedef struct packed {
      logic [N_W-1:0] n;
      logic [D_W-1:0] a;
      logic [D_W-1:0] b;
   } job_s;

   typedef struct {
      logic [N_W-1:0] n;
      logic [D_W-1:0] a;
      logic [D_W-1:0] b;
      int             lat;
      logic [D_W-1:0] exp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int core_lat = 4;
   bit core_level = 1'b0;
   bit core_rand = 1'b0;
   int epoch = 0;
   int resp_cnt = 0;
   job_s exp_q[$];
   logic [D_W-1:0] got_res[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // f(0)=b, f(1)=a, f(k)=f(k-1)+f(k-2), modulo 2^D_W.
   function automatic logic [D_W-1:0] fib(input logic [N_W-1:0] n, input logic [D_W-1:0] a,
                                          input logic [D_W-1:0] b);
      logic [D_W-1:0] p, q, t;
      p = b;
      q = a;
      if (n == 0) return b;
      for (int i = 1; i < int'(n); i++) begin
         t = p + q;
         p = q;
         q = t;
      end
      return q;
   endfunction

   // Behavioural core: pulse or level completion, abandons the job if reset intervenes.
   initial begin
      logic [D_W-1:0] r;
      int l, ep;
      bus.core_w_enable = 1'b0;
      bus.core_result   = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && bus.core_r_enable) begin
            r  = fib(bus.core_init_n, bus.core_init_a, bus.core_init_b);
            ep = epoch;
            l  = core_rand ? int'($urandom_range(30, 1)) : core_lat;
            if (core_level) begin
               repeat (3) @(posedge clk);
               #1;
            end
            bus.core_w_enable = 1'b0;
            for (int k = 0; k < l && ep == epoch; k++) @(posedge clk);
            #1;
            if (ep == epoch) begin
               bus.core_result   = r;
               bus.core_w_enable = 1'b1;
               if (!core_level) begin
                  @(posedge clk);
                  #1 bus.core_w_enable = 1'b0;
               end
            end
         end
      end
   end

   // Scoreboard: launch order, operand stability, response contents.
   initial begin
      job_s j, cur;
      bit active;
      active = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            active = 1'b0;
         end else begin
            chk("ctrl_arr", bus.core_controlArr, 0);
            if (bus.in_valid && bus.in_ready) begin
               j.n = bus.in_n; j.a = bus.in_a; j.b = bus.in_b;
               exp_q.push_back(j);
            end
            if (bus.core_r_enable) begin
               chk("launch_while_active", active, 0);
               chk("launch_queued", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  cur = exp_q[0];
                  chk("launch_job", {bus.core_init_n, bus.core_init_a, bus.core_init_b}, cur);
               end
               active = 1'b1;
            end else if (active) begin
               chk("init_stable", {bus.core_init_n, bus.core_init_a, bus.core_init_b}, cur);
            end
            if (bus.out_valid && bus.out_ready) begin
               chk("resp_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  j = exp_q.pop_front();
                  chk("resp", {bus.out_n, bus.out_result, bus.out_timeout},
                      {j.n, fib(j.n, j.a, j.b), 1'b0});
               end
               got_res.push_back(bus.out_result);
               resp_cnt++;
               active = 1'b0;
            end
         end
      end
   end

   task automatic push(input logic [N_W-1:0] n, input logic [D_W-1:0] a, input logic [D_W-1:0] b,
                       output int w);
      w = 0;
      bus.in_valid = 1'b1; bus.in_n = n; bus.in_a = a; bus.in_b = b;
      @(negedge clk);
      while (!bus.in_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      chk("push_accepted", bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic run_single(input vec_t v, input string tag);
      int w, cyc, exp_cyc;
      core_lat = v.lat;
      exp_cyc = core_level ? v.lat + 4 : v.lat + 1;
      push(v.n, v.a, v.b, w);
      @(negedge clk); chk({tag, "_ren_e0"}, bus.core_r_enable, 0);
      @(negedge clk); chk({tag, "_ren_e1"}, bus.core_r_enable, 1);
      @(negedge clk); chk({tag, "_ren_e2"}, bus.core_r_enable, 0);
      cyc = 1;
      while (!bus.out_valid && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, cyc, exp_cyc);
      chk({tag, "_resp"}, {bus.out_valid, bus.out_n, bus.out_result, bus.out_timeout},
          {1'b1, v.n, v.exp, 1'b0});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation bound exceeded");
   end

   initial begin
      vec_t vecs[8];
      vec_t lv[2];
      vec_t post;
      logic [D_W-1:0] t2_exp[6];
      int w, k, base, sent;
      bit ready_s, hs;

      vecs[0] = '{6'd40, 32'd1, 32'd0, 50, 32'd102334155};
      vecs[1] = '{6'd10, 32'd1, 32'd0, 3,  32'd55};
      vecs[2] = '{6'd0,  32'd7, 32'd9, 4,  32'd9};
      vecs[3] = '{6'd1,  32'd7, 32'd9, 2,  32'd7};
      vecs[4] = '{6'd2,  32'd3, 32'd4, 1,  32'd7};
      vecs[5] = '{6'd47, 32'd1, 32'd0, 8,  32'd2971215073};
      vecs[6] = '{6'd48, 32'd1, 32'd0, 5,  32'd512559680};
      vecs[7] = '{6'd5,  32'd2, 32'd1, 6,  32'd13};
      lv[0]   = '{6'd15, 32'd1, 32'd0, 30, 32'd610};
      lv[1]   = '{6'd16, 32'd1, 32'd0, 30, 32'd987};
      post    = '{6'd30, 32'd1, 32'd0, 7,  32'd832040};
      t2_exp  = '{32'd34, 32'd55, 32'd89, 32'd144, 32'd233, 32'd377};

      bus.in_valid = 1'b0; bus.in_n = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_n = '0; bus2.in_a = '0; bus2.in_b = '0; bus2.out_ready = 1'b1;
      bus2.core_w_enable = 1'b0; bus2.core_result = 32'hDEAD_BEEF;

      // Reset takes effect before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out", {bus.out_valid, bus.out_n, bus.out_result, bus.out_timeout}, 0);
      chk("rst_core", {bus.core_r_enable, bus.core_init_n, bus.core_init_a, bus.core_init_b}, 0);
      chk("rst_busy", {busy, busy2}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", {bus.in_ready, bus2.in_ready}, 2'b11);
      chk("rel_idle", {busy, bus.out_valid, bus.core_r_enable}, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) run_single(vecs[i], $sformatf("vec%0d", i));

      // FIFO fill while the core is busy, fifth job waits for the first pop.
      base = resp_cnt;
      core_lat = 12;
      push(6'd9, 32'd1, 32'd0, w);
      for (int i = 10; i <= 13; i++) push(N_W'(i), 32'd1, 32'd0, w);
      @(negedge clk);
      chk("t2_full_ready", bus.in_ready, 0);
      chk("t2_busy", busy, 1);
      @(posedge clk);
      #1;
      push(6'd14, 32'd1, 32'd0, w);
      chk("t2_14_waited", w > 0, 1);
      chk("t2_14_after_first_pop", resp_cnt - base, 1);
      for (k = 0; k < 3000 && resp_cnt < base + 6; k++) @(negedge clk);
      chk("t2_drain", resp_cnt - base, 6);
      for (int i = 0; i < 6; i++)
         if (got_res.size() > base + i) chk($sformatf("t2_order%0d", i), got_res[base + i], t2_exp[i]);
      @(posedge clk);
      #1;

      // Output stall with a job queued behind it.
      base = resp_cnt;
      core_lat = 5;
      bus.out_ready = 1'b0;
      push(6'd12, 32'd1, 32'd0, w);
      push(6'd7, 32'd1, 32'd0, w);
      k = 0;
      while (!bus.out_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t3_valid_seen", bus.out_valid, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t3_stall", {bus.out_valid, bus.out_n, bus.out_result, bus.out_timeout, bus.core_r_enable},
             {1'b1, 6'd12, 32'd144, 1'b0, 1'b0});
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk); chk("t3_valid_before_hs", bus.out_valid, 1);
      @(negedge clk); chk("t3_idle_gap", {bus.out_valid, bus.core_r_enable}, 2'b00);
      @(negedge clk); chk("t3_next_launch", bus.core_r_enable, 1);
      for (k = 0; k < 200 && resp_cnt < base + 2; k++) @(negedge clk);
      chk("t3_both_resp", resp_cnt - base, 2);
      @(posedge clk);
      #1;

      // Watchdog on the second unit, whose core never completes.
      bus2.in_valid = 1'b1; bus2.in_n = 6'd5; bus2.in_a = 32'd1; bus2.in_b = 32'd0;
      @(posedge clk);
      #1 bus2.in_n = 6'd6;
      @(posedge clk);
      #1 bus2.in_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus2.core_r_enable && k < 10);
      chk("t4_launch_n5", {bus2.core_r_enable, bus2.core_init_n}, {1'b1, 6'd5});
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus2.out_valid && k < 100);
      chk("t4_timeout_cycles", k, 17);
      chk("t4_resp_n5", {bus2.out_valid, bus2.out_n, bus2.out_result, bus2.out_timeout},
          {1'b1, 6'd5, 32'd0, 1'b1});
      @(negedge clk); chk("t4_valid_drop", bus2.out_valid, 0);
      @(negedge clk); chk("t4_launch_n6", {bus2.core_r_enable, bus2.core_init_n}, {1'b1, 6'd6});
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus2.out_valid && k < 100);
      chk("t4_resp_n6", {bus2.out_valid, bus2.out_n, bus2.out_result, bus2.out_timeout},
          {1'b1, 6'd6, 32'd0, 1'b1});
      @(negedge clk);
      @(negedge clk); chk("t4_idle", busy2, 0);
      @(posedge clk);
      #1;

      // Level-style core: stale high from the previous job must not complete the next one.
      core_level = 1'b1;
      run_single(lv[0], "lvl0");
      run_single(lv[1], "lvl1");
      core_level = 1'b0;

      // Randomised traffic with random backpressure and core latency.
      base = resp_cnt;
      core_rand = 1'b1;
      sent = 0;
      ready_s = 1'b0;
      for (k = 0; k < 20000; k++) begin
         @(posedge clk);
         hs = bus.in_valid && ready_s;
         #1;
         if (hs) sent++;
         if (!bus.in_valid || hs) begin
            if (sent < NRAND && ($urandom % 3) != 0) begin
               bus.in_valid = 1'b1;
               bus.in_n = N_W'($urandom_range(63, 0));
               bus.in_a = $urandom;
               bus.in_b = $urandom;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready = ($urandom % 4) != 0;
         @(negedge clk);
         ready_s = bus.in_ready;
         if (sent == NRAND && resp_cnt == base + NRAND) break;
      end
      chk("rand_all_resp", resp_cnt - base, NRAND);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      core_rand = 1'b0;
      @(posedge clk);
      #1;

      // Reset mid-WAIT with two jobs queued.
      core_lat = 40;
      push(6'd20, 32'd1, 32'd0, w);
      push(6'd3, 32'd1, 32'd0, w);
      push(6'd4, 32'd1, 32'd0, w);
      repeat (5) @(negedge clk);
      chk("t5_in_wait", busy, 1);
      #2;
      epoch++;
      rst_n = 1'b0;
      #1;
      chk("t5_async_out", {bus.out_valid, bus.out_n, bus.out_result, bus.out_timeout}, 0);
      chk("t5_async_ctl", {busy, bus.in_ready, bus.core_r_enable, bus.core_init_n, bus.core_init_a}, 0);
      repeat (3) begin
         @(negedge clk);
         chk("t5_ren_low", bus.core_r_enable, 0);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("t5_release", {bus.in_ready, busy, bus.out_valid, bus.core_r_enable}, 4'b1000);
      @(posedge clk);
      #1;
      run_single(post, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
